// File: rtl/mm_score_sequencer.sv
// mm_score_sequencer: multi-cycle Mastermind scorer (4-cycle exact pass, 16-cycle colour pass)
// with round counting and sticky win/lose.
module mm_score_sequencer #(
    parameter int COLOR_W    = 3,
    parameter int MAX_ROUNDS = 10
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 new_game,
    input  logic                 start,
    input  logic [4*COLOR_W-1:0] code_flat,
    input  logic [4*COLOR_W-1:0] guess_flat,
    output logic                 busy,
    output logic                 done,
    output logic [2:0]           black,
    output logic [2:0]           white,
    output logic [3:0]           round,
    output logic                 win,
    output logic                 lose,
    output logic                 game_over
);
    typedef enum logic [2:0] {IDLE, EXACT, PARTIAL, FINISH, OVER} state_t;
    state_t               r_state;
    logic [4*COLOR_W-1:0] r_code, r_guess;
    logic [3:0]           r_code_used, r_guess_used;
    logic [1:0]           r_i, r_j;
    logic [2:0]           r_black, r_white;
    logic [3:0]           r_round;
    logic                 r_win, r_lose;
    logic [COLOR_W-1:0]   w_code_i, w_code_j, w_guess_i;
    logic                 w_partial_hit;
    assign w_code_i      = r_code[r_i*COLOR_W +: COLOR_W];
    assign w_code_j      = r_code[r_j*COLOR_W +: COLOR_W];
    assign w_guess_i     = r_guess[r_i*COLOR_W +: COLOR_W];
    assign w_partial_hit = !r_guess_used[r_i] && !r_code_used[r_j] && (w_guess_i == w_code_j);
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_code       <= '0;
            r_guess      <= '0;
            r_code_used  <= '0;
            r_guess_used <= '0;
            r_i          <= '0;
            r_j          <= '0;
            r_black      <= '0;
            r_white      <= '0;
            r_round      <= '0;
            r_win        <= 1'b0;
            r_lose       <= 1'b0;
        end else if (new_game) begin
            r_state      <= IDLE;
            r_code_used  <= '0;
            r_guess_used <= '0;
            r_black      <= '0;
            r_white      <= '0;
            r_round      <= '0;
            r_win        <= 1'b0;
            r_lose       <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (start) begin
                    r_code       <= code_flat;
                    r_guess      <= guess_flat;
                    r_code_used  <= '0;
                    r_guess_used <= '0;
                    r_black      <= '0;
                    r_white      <= '0;
                    r_i          <= '0;
                    r_state      <= EXACT;
                end
                EXACT: begin
                    if (w_code_i == w_guess_i) begin
                        r_black             <= r_black + 3'd1;
                        r_code_used[r_i]    <= 1'b1;
                        r_guess_used[r_i]   <= 1'b1;
                    end
                    r_i <= r_i + 2'd1;
                    if (r_i == 2'd3) begin
                        r_j     <= '0;
                        r_state <= PARTIAL;
                    end
                end
                PARTIAL: begin
                    // used-flags guarantee each peg is counted once, so black+white <= 4
                    if (w_partial_hit) begin
                        r_white           <= r_white + 3'd1;
                        r_guess_used[r_i] <= 1'b1;
                        r_code_used[r_j]  <= 1'b1;
                    end
                    r_j <= r_j + 2'd1;
                    if (r_j == 2'd3) begin
                        r_i <= r_i + 2'd1;
                        if (r_i == 2'd3) r_state <= FINISH;
                    end
                end
                FINISH: begin
                    r_round <= r_round + 4'd1;
                    if (r_black == 3'd4) begin
                        r_win   <= 1'b1;
                        r_state <= OVER;
                    end else if (r_round + 4'd1 == 4'(MAX_ROUNDS)) begin
                        r_lose  <= 1'b1;
                        r_state <= OVER;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                OVER: r_state <= OVER;
                default: r_state <= IDLE;
            endcase
        end
    end
    assign busy      = (r_state == EXACT) || (r_state == PARTIAL) || (r_state == FINISH);
    assign done      = (r_state == FINISH);
    assign black     = r_black;
    assign white     = r_white;
    assign round     = r_round;
    assign win       = r_win;
    assign lose      = r_lose;
    assign game_over = r_win || r_lose;
endmodule

// File: tb/tb_mm_score_sequencer.sv
// tb_mm_score_sequencer: directed and random scoring games checked against a
// colour-count reference model of the Mastermind rules.
module tb_mm_score_sequencer;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        new_game = 1'b0;
    logic        start = 1'b0;
    logic [11:0] code_flat = '0;
    logic [11:0] guess_flat = '0;
    logic        busy, done, win, lose, game_over;
    logic [2:0]  black, white;
    logic [3:0]  round;
    int n_checks = 0;
    int n_errs = 0;
    int m_round = 0;
    int m_win = 0;
    int m_lose = 0;

    mm_score_sequencer #(.COLOR_W(3), .MAX_ROUNDS(10)) dut (
        .clk(clk), .reset(reset), .new_game(new_game), .start(start),
        .code_flat(code_flat), .guess_flat(guess_flat), .busy(busy), .done(done),
        .black(black), .white(white), .round(round), .win(win), .lose(lose),
        .game_over(game_over)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errs++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [11:0] pk(input int a, input int b, input int c, input int d);
        logic [2:0] a3, b3, c3, d3;
        a3 = a[2:0]; b3 = b[2:0]; c3 = c[2:0]; d3 = d[2:0];
        return {d3, c3, b3, a3};
    endfunction

    // black = positional matches; white = shared colour multiset size minus black
    function automatic void ref_score(input logic [11:0] c, input logic [11:0] g,
                                      output int b, output int w);
        int cc[8];
        int cg[8];
        b = 0; w = 0;
        for (int k = 0; k < 8; k++) begin cc[k] = 0; cg[k] = 0; end
        for (int k = 0; k < 4; k++) begin
            if (c[3*k +: 3] == g[3*k +: 3]) b++;
            cc[c[3*k +: 3]]++;
            cg[g[3*k +: 3]]++;
        end
        for (int k = 0; k < 8; k++) w += (cc[k] < cg[k]) ? cc[k] : cg[k];
        w -= b;
    endfunction

    task automatic check_game(input string tag);
        chk({tag, ".round"}, round, m_round);
        chk({tag, ".win"}, win, m_win);
        chk({tag, ".lose"}, lose, m_lose);
        chk({tag, ".game_over"}, game_over, (m_win | m_lose));
    endtask

    task automatic run_guess(input logic [11:0] c, input logic [11:0] g, input bit poke);
        int lat, eb, ew;
        @(negedge clk);
        code_flat = c; guess_flat = g; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 1;
        chk("busy_after_start", busy, 1);
        code_flat = 12'($urandom);
        guess_flat = 12'($urandom);
        while (!done && lat < 40) begin
            start = poke && (lat == 8);
            @(posedge clk); #1;
            lat++;
        end
        start = 1'b0;
        ref_score(c, g, eb, ew);
        chk("latency", lat, 21);
        chk("black", black, eb);
        chk("white", white, ew);
        m_round++;
        if (eb == 4) m_win = 1;
        else if (m_round == 10) m_lose = 1;
        @(posedge clk); #1;
        chk("done_one_cycle", done, 0);
        chk("busy_after_done", busy, 0);
        chk("black_hold", black, eb);
        check_game("post");
    endtask

    task automatic pulse_new_game();
        @(negedge clk); new_game = 1'b1;
        @(posedge clk); #1; new_game = 1'b0;
        m_round = 0; m_win = 0; m_lose = 0;
    endtask

    task automatic try_start(input string tag);
        @(negedge clk); start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        chk(tag, busy, 0);
    endtask

    initial begin
        int lat, seen;
        repeat (3) @(posedge clk);
        #1;
        chk("rst.busy", busy, 0);
        chk("rst.done", done, 0);
        chk("rst.black", black, 0);
        chk("rst.white", white, 0);
        check_game("rst");
        @(negedge clk); reset = 1'b0;

        run_guess(pk(1,2,3,4), pk(1,2,3,4), 0);
        try_start("over_ignores_start");
        pulse_new_game();
        check_game("newgame");
        run_guess(pk(1,1,2,2), pk(2,2,1,1), 0);
        run_guess(pk(1,1,2,3), pk(1,3,1,1), 0);
        run_guess(pk(5,5,5,5), pk(5,0,0,0), 0);

        pulse_new_game();
        for (int k = 0; k < 10; k++) run_guess(pk(7,6,5,4), pk(0,0,0,0), 0);
        try_start("lost_ignores_start");
        chk("lost.round", round, 10);

        pulse_new_game();
        run_guess(pk(3,1,4,1), pk(1,4,1,3), 1);

        // abort in cycle 12 with new_game
        @(negedge clk); code_flat = pk(2,2,2,2); guess_flat = pk(2,2,3,3); start = 1'b1;
        @(posedge clk); #1; start = 1'b0; lat = 1;
        while (lat < 12) begin @(posedge clk); #1; lat++; end
        chk("abort.busy_before", busy, 1);
        new_game = 1'b1;
        @(posedge clk); #1; new_game = 1'b0;
        m_round = 0; m_win = 0; m_lose = 0;
        chk("abort.busy", busy, 0);
        chk("abort.black", black, 0);
        chk("abort.white", white, 0);
        check_game("abort");
        seen = 0;
        repeat (25) begin @(posedge clk); #1; if (done) seen++; end
        chk("abort.no_done", seen, 0);

        @(negedge clk); start = 1'b1; new_game = 1'b1;
        @(posedge clk); #1; start = 1'b0; new_game = 1'b0;
        chk("start_and_newgame", busy, 0);

        // async reset mid-PARTIAL
        run_guess(pk(6,6,1,1), pk(1,1,6,6), 0);
        @(negedge clk); code_flat = pk(1,2,3,4); guess_flat = pk(4,3,2,1); start = 1'b1;
        @(posedge clk); #1; start = 1'b0; lat = 1;
        while (lat < 18) begin @(posedge clk); #1; lat++; end
        #2 reset = 1'b1;
        #1;
        chk("arst.busy", busy, 0);
        chk("arst.black", black, 0);
        chk("arst.white", white, 0);
        chk("arst.round", round, 0);
        @(negedge clk); reset = 1'b0;
        m_round = 0; m_win = 0; m_lose = 0;
        run_guess(pk(1,2,3,4), pk(4,3,2,1), 0);

        for (int k = 0; k < 40; k++) begin
            logic [11:0] c, g;
            if (game_over) pulse_new_game();
            c = pk($urandom_range(0,3), $urandom_range(0,3), $urandom_range(0,3), $urandom_range(0,7));
            g = ($urandom_range(0,7) == 0) ? c :
                pk($urandom_range(0,3), $urandom_range(0,3), $urandom_range(0,3), $urandom_range(0,7));
            run_guess(c, g, bit'($urandom_range(0,1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end
endmodule
